systolic_row_feeder: RTL and testbench
======================================

Name: systolic_row_feeder

Overview:
Input skew stage that feeds the IN_LEFT side of an N-row systolic array of FP32 processing elements. It buffers one N x N FP32 operand matrix, loaded one row per handshake. On START it streams the matrix diagonally: lane i is delayed i cycles and padded with FP32 zero. After the data it drives a zero flush so each PE's multiply/accumulate pipeline drains before DONE.

Parameters:
N, 4, array dimension (rows of the matrix = output lanes = elements per row)
DATA_W, 32, element width (IEEE-754 single)
FLUSH_CYCLES, 4, zero-valued OUT_VALID cycles appended after the data so PE pipelines drain

Ports:
CLK  in  1  clock, all state updates on posedge
RST_N  in  1  asynchronous active-low reset
LOAD_VALID  in  1  LOAD_ROW holds a valid row
LOAD_READY  out  1  feeder can accept a row
LOAD_ROW  in  N*DATA_W  one matrix row; element k at bits [k*DATA_W +: DATA_W]
START  in  1  begin streaming the loaded matrix
OUT_LANES  out  N*DATA_W  lane i at bits [i*DATA_W +: DATA_W], drives IN_LEFT of array row i
OUT_VALID  out  1  OUT_LANES belongs to an active stream or flush cycle
BUSY  out  1  high in STREAM and FLUSH
DONE  out  1  one-cycle pulse at end of flush

Behaviour:
- One clock, CLK. Reset is asynchronous and active-low on RST_N. All registers clear immediately when RST_N falls, independent of CLK.
- Reset values: state=IDLE, row_cnt=0, t=0, buffer=0, OUT_LANES=0, OUT_VALID=0, BUSY=0, DONE=0, LOAD_READY=1 one cycle after RST_N deasserts.
- Every output is registered. FP zero is 32'h0000_0000.
- IDLE (load phase):
  - LOAD_READY=1.
  - A handshake (LOAD_VALID & LOAD_READY at posedge) writes LOAD_ROW into buffer row row_cnt, then increments row_cnt.
  - The handshake with row_cnt=N-1 sets row_cnt=0 and moves to LOADED.
  - START is ignored in IDLE.
- LOADED:
  - LOAD_READY=0.
  - START high at posedge k moves to STREAM with t=0. OUT_LANES for t=0 is visible after edge k.
- STREAM:
  - Lasts 2N-1 cycles, t=0..2N-2.
  - Lane i = buffer[i][t-i] when 0 <= t-i <= N-1, otherwise FP zero.
  - OUT_VALID=1, BUSY=1. After t=2N-2, go to FLUSH.
- FLUSH:
  - Lasts FLUSH_CYCLES cycles. OUT_LANES=0, OUT_VALID=1, BUSY=1.
  - FLUSH_CYCLES=0 skips FLUSH entirely.
- DONE:
  - Single cycle. DONE=1, OUT_VALID=0, OUT_LANES=0. Then IDLE with LOAD_READY=1.
  - Buffer contents are retained until overwritten.
- Outside STREAM/FLUSH: OUT_LANES=0, OUT_VALID=0.
- Latency from START edge to last nonzero lane value: 2N-2 cycles. From START edge to DONE: 2N-1+FLUSH_CYCLES cycles.
- Boundary cases:
  - START held high continuously: only the LOADED->STREAM edge acts. It does not retrigger after DONE, because a new load is required.
  - START during STREAM, FLUSH, DONE or IDLE: ignored.
  - LOAD_VALID outside IDLE: no write, LOAD_READY stays 0.
  - LOAD_VALID held with stalls between rows: only handshake cycles count.
  - Reset mid-load or mid-stream: immediate return to reset values, partial matrix discarded, no DONE pulse.
  - Elements are passed bit-exact, including -0.0, NaN and denormals. The feeder does no arithmetic.

Decomposition:
- Shared define header (existing FP constants file) holds FPZero and the default array dimension, so the feeder and PE grid agree on N.
- Natural sub-module: skew_lane_mux. It is combinational, takes one buffered row, t and the lane index, and returns the element or FP zero. Instantiate it N times via generate.
- State machine, counters and buffer stay in the top module.

Test Plan:
- Reset/idle: assert RST_N=0 mid-cycle -> outputs 0 immediately; after release LOAD_READY=1, OUT_VALID=0, DONE=0.
- Load then stream, N=4: load row r element c = 32'h4000_0000 + 4r + c, pulse START.
  - t=0 lanes: {0,0,0,40000000}, lane0 = A[0][0].
  - t=3 lanes: lane0=40000003, lane1=40000006, lane2=40000009, lane3=4000000C.
  - t=6 lanes: lane3=4000000F, others 0.
  - Then 4 zero cycles with OUT_VALID=1, then DONE=1 for exactly one cycle 11 cycles after the START edge.
- Backpressure and spurious inputs: insert LOAD_VALID gaps between rows and pulse START after only 2 rows -> no stream. Stream starts only after the 4th handshake plus START.
- Reset mid-stream: drop RST_N at t=3 -> OUT_VALID=0 and OUT_LANES=0 immediately, no DONE. After release a fresh 4-row load is required before START acts.
- Special values: load -0.0 (80000000), +Inf (7F800000) and NaN (7FC00000) -> the same bit patterns appear on the correct lanes and cycles, unmodified.
- FLUSH_CYCLES=0 variant: DONE asserts in the cycle right after t=6, and OUT_VALID drops in that same cycle.

Source files
------------

// File: rtl/systolic_row_feeder_pkg.sv
// Shared constants for the systolic feeder: FP zero pattern, default array size
// and the feeder state encoding.
package systolic_row_feeder_pkg;

   localparam int              DEFAULT_N = 4;
   localparam int              FP_W      = 32;
   localparam logic [FP_W-1:0] FP_ZERO   = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOADED,
      ST_STREAM,
      ST_FLUSH,
      ST_DONE
   } feeder_state_e;

endpackage

// File: rtl/systolic_row_feeder_skew_lane_mux.sv
// One skew lane: picks row element (t - lane) when it lies inside the row,
// otherwise FP zero. Purely combinational, bit-exact pass-through.
module skew_lane_mux
   import systolic_row_feeder_pkg::*;
#(
   parameter int N      = DEFAULT_N,
   parameter int DATA_W = FP_W,
   parameter int TW     = 3
) (
   input  logic [N*DATA_W-1:0] row_i,
   input  logic [TW-1:0]       t_i,
   input  logic [TW-1:0]       lane_i,
   output logic [DATA_W-1:0]   elem_o
);

   always_comb begin
      elem_o = DATA_W'(FP_ZERO);
      for (int k = 0; k < N; k++) begin
         if (t_i >= lane_i && (t_i - lane_i) == TW'(k)) begin
            elem_o = row_i[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/systolic_row_feeder.sv
// Input skew stage for the IN_LEFT edge of an N-row systolic array: buffers an
// N x N matrix row by row, then streams it diagonally followed by a zero flush.
module systolic_row_feeder
   import systolic_row_feeder_pkg::*;
#(
   parameter int N            = DEFAULT_N,
   parameter int DATA_W       = FP_W,
   parameter int FLUSH_CYCLES = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                load_valid_i,
   output logic                load_ready_o,
   input  logic [N*DATA_W-1:0] load_row_i,
   input  logic                start_i,
   output logic [N*DATA_W-1:0] out_lanes_o,
   output logic                out_valid_o,
   output logic                busy_o,
   output logic                done_o
);

   localparam int TW = $clog2(2*N);
   localparam int RW = (N > 1) ? $clog2(N) : 1;
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(2*N-2);
   localparam logic [RW-1:0] R_LAST = RW'(N-1);
   localparam logic [FW-1:0] F_LAST = FW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES-1 : 0);

   feeder_state_e       state_q, state_d;
   logic [RW-1:0]       row_cnt_q, row_cnt_d;
   logic [TW-1:0]       t_q, t_d;
   logic [FW-1:0]       f_q, f_d;
   logic                wr_en;
   logic [N*DATA_W-1:0] buf_q [N];
   logic [N*DATA_W-1:0] lanes_d;

   logic                load_ready_q;
   logic [N*DATA_W-1:0] out_lanes_q;
   logic                out_valid_q;
   logic                busy_q;
   logic                done_q;

   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      t_d       = t_q;
      f_d       = f_q;
      wr_en     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_valid_i && load_ready_q) begin
               wr_en = 1'b1;
               if (row_cnt_q == R_LAST) begin
                  row_cnt_d = '0;
                  state_d   = ST_LOADED;
               end else begin
                  row_cnt_d = row_cnt_q + RW'(1);
               end
            end
         end
         ST_LOADED: begin
            if (start_i) begin
               state_d = ST_STREAM;
               t_d     = '0;
            end
         end
         ST_STREAM: begin
            if (t_q == T_LAST) begin
               t_d     = '0;
               f_d     = '0;
               state_d = (FLUSH_CYCLES == 0) ? ST_DONE : ST_FLUSH;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         ST_FLUSH: begin
            if (f_q == F_LAST) state_d = ST_DONE;
            else               f_d     = f_q + FW'(1);
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Lanes are computed from the next-cycle t so the registered output lines up with state.
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      skew_lane_mux #(
         .N      (N),
         .DATA_W (DATA_W),
         .TW     (TW)
      ) u_lane (
         .row_i  (buf_q[gi]),
         .t_i    (t_d),
         .lane_i (TW'(gi)),
         .elem_o (lanes_d[gi*DATA_W +: DATA_W])
      );
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         row_cnt_q    <= '0;
         t_q          <= '0;
         f_q          <= '0;
         for (int r = 0; r < N; r++) buf_q[r] <= '0;
         load_ready_q <= 1'b0;
         out_lanes_q  <= '0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_cnt_q    <= row_cnt_d;
         t_q          <= t_d;
         f_q          <= f_d;
         if (wr_en) buf_q[row_cnt_q] <= load_row_i;
         load_ready_q <= (state_d == ST_IDLE);
         out_lanes_q  <= (state_d == ST_STREAM) ? lanes_d : '0;
         out_valid_q  <= (state_d == ST_STREAM) || (state_d == ST_FLUSH);
         busy_q       <= (state_d == ST_STREAM) || (state_d == ST_FLUSH);
         done_q       <= (state_d == ST_DONE);
      end
   end

   assign load_ready_o = load_ready_q;
   assign out_lanes_o  = out_lanes_q;
   assign out_valid_o  = out_valid_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Directed bench for systolic_row_feeder: one instance with a 4-cycle flush and
// one with no flush, driven by the same stimulus.
module tb_systolic_row_feeder;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           load_valid = 1'b0;
   logic           start = 1'b0;
   logic [N*W-1:0] load_row = '0;

   logic           a_ready, a_valid, a_busy, a_done;
   logic [N*W-1:0] a_lanes;
   logic           b_ready, b_valid, b_busy, b_done;
   logic [N*W-1:0] b_lanes;

   systolic_row_feeder #(.N(N), .DATA_W(W), .FLUSH_CYCLES(4)) dut_a (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .load_valid_i (load_valid),
      .load_ready_o (a_ready),
      .load_row_i   (load_row),
      .start_i      (start),
      .out_lanes_o  (a_lanes),
      .out_valid_o  (a_valid),
      .busy_o       (a_busy),
      .done_o       (a_done)
   );

   systolic_row_feeder #(.N(N), .DATA_W(W), .FLUSH_CYCLES(0)) dut_b (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .load_valid_i (load_valid),
      .load_ready_o (b_ready),
      .load_row_i   (load_row),
      .start_i      (start),
      .out_lanes_o  (b_lanes),
      .out_valid_o  (b_valid),
      .busy_o       (b_busy),
      .done_o       (b_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // flags packed as {valid, busy, done, ready}
   typedef struct {
      logic [N*W-1:0] lanes;
      logic [3:0]     fa;
      logic [3:0]     fb;
   } vec_t;

   vec_t           tbl[13];
   logic [N*W-1:0] sp[4];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [N*W-1:0] mk(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [N*W-1:0] a_row(input int r);
      logic [31:0] base;
      base = 32'h4000_0000 + 32'(4*r);
      return mk(base, base + 32'd1, base + 32'd2, base + 32'd3);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [N*W-1:0] row, input int gaps, input string tag);
      load_valid = 1'b0;
      repeat (gaps) step();
      chk({tag, " ready"}, 128'(a_ready), 128'(1'b1));
      load_valid = 1'b1;
      load_row   = row;
      step();
      load_valid = 1'b0;
      load_row   = '0;
      $display("load %s row=%h", tag, row);
   endtask

   task automatic run_stream(input bit hold_start, input string tag);
      start = 1'b1;
      step();
      if (!hold_start) start = 1'b0;
      for (int c = 0; c < 13; c++) begin
         chk($sformatf("%s a_lanes c%0d", tag, c), 128'(a_lanes), 128'(tbl[c].lanes));
         chk($sformatf("%s a_flags c%0d", tag, c), 128'({a_valid, a_busy, a_done, a_ready}), 128'(tbl[c].fa));
         chk($sformatf("%s b_lanes c%0d", tag, c), 128'(b_lanes), 128'(tbl[c].lanes));
         chk($sformatf("%s b_flags c%0d", tag, c), 128'({b_valid, b_busy, b_done, b_ready}), 128'(tbl[c].fb));
         $display("%s c=%0d lanes=%h v=%b d=%b | b lanes=%h v=%b d=%b",
                  tag, c, a_lanes, a_valid, a_done, b_lanes, b_valid, b_done);
         // spurious writes while busy must not reach the buffer
         load_valid = (c < 5);
         load_row   = {N*W{1'b1}};
         step();
      end
      load_valid = 1'b0;
      load_row   = '0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("%s no_retrigger a %0d", tag, c), 128'({a_valid, a_busy, a_done, a_ready}), 128'(4'b0001));
         chk($sformatf("%s no_retrigger b %0d", tag, c), 128'({b_valid, b_busy, b_done, b_ready}), 128'(4'b0001));
         step();
      end
      start = 1'b0;
   endtask

   initial begin
      tbl[0].lanes = mk(32'h4000_0000, 32'h0, 32'h0, 32'h0);
      tbl[1].lanes = mk(32'h4000_0001, 32'h4000_0004, 32'h0, 32'h0);
      tbl[2].lanes = mk(32'h4000_0002, 32'h4000_0005, 32'h4000_0008, 32'h0);
      tbl[3].lanes = mk(32'h4000_0003, 32'h4000_0006, 32'h4000_0009, 32'h4000_000C);
      tbl[4].lanes = mk(32'h0, 32'h4000_0007, 32'h4000_000A, 32'h4000_000D);
      tbl[5].lanes = mk(32'h0, 32'h0, 32'h4000_000B, 32'h4000_000E);
      tbl[6].lanes = mk(32'h0, 32'h0, 32'h0, 32'h4000_000F);
      for (int c = 0; c < 13; c++) begin
         if (c > 6) tbl[c].lanes = '0;
         tbl[c].fa = (c <= 10) ? 4'b1100 : (c == 11) ? 4'b0010 : 4'b0001;
         tbl[c].fb = (c <= 6)  ? 4'b1100 : (c == 7)  ? 4'b0010 : 4'b0001;
      end
      sp[0] = mk(32'h8000_0000, 32'h0, 32'h0, 32'h0);
      sp[1] = mk(32'h7F80_0000, 32'h7FC0_0001, 32'h0, 32'h0);
      sp[2] = mk(32'h7FC0_0000, 32'h8000_0000, 32'hFF80_0000, 32'h0);
      sp[3] = mk(32'h0000_0001, 32'h007F_FFFF, 32'h8000_0001, 32'h7F80_0000);

      // Reset held: everything low, including ready.
      #2;
      chk("reset a_flags", 128'({a_valid, a_busy, a_done, a_ready}), 128'(4'b0000));
      chk("reset a_lanes", 128'(a_lanes), 128'(0));
      #21 rst_n = 1'b1;
      step();
      chk("post_reset a_flags", 128'({a_valid, a_busy, a_done, a_ready}), 128'(4'b0001));
      chk("post_reset b_flags", 128'({b_valid, b_busy, b_done, b_ready}), 128'(4'b0001));

      // Gapped load with an early START after two rows.
      load(a_row(0), 2, "r0");
      load(a_row(1), 1, "r1");
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("early_start a_flags", 128'({a_valid, a_busy, a_done, a_ready}), 128'(4'b0001));
      chk("early_start b_flags", 128'({b_valid, b_busy, b_done, b_ready}), 128'(4'b0001));
      load(a_row(2), 3, "r2");
      load(a_row(3), 0, "r3");
      repeat (2) begin
         chk("loaded a_flags", 128'({a_valid, a_busy, a_done, a_ready}), 128'(4'b0000));
         chk("loaded a_lanes", 128'(a_lanes), 128'(0));
         step();
      end
      run_stream(1'b1, "run1");

      // Special values, then reset in the middle of the stream at t=3.
      load(mk(32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0001), 0, "s0");
      load(mk(32'h7FC0_0001, 32'h8000_0000, 32'h007F_FFFF, 32'h7F80_0000), 0, "s1");
      load(mk(32'hFF80_0000, 32'h8000_0001, 32'h8000_0000, 32'h3F80_0000), 0, "s2");
      load(mk(32'h7F80_0000, 32'hFFC0_0000, 32'h0000_0000, 32'h8000_0000), 0, "s3");
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("special a_lanes t%0d", c), 128'(a_lanes), 128'(sp[c]));
         chk($sformatf("special b_lanes t%0d", c), 128'(b_lanes), 128'(sp[c]));
         $display("special t=%0d lanes=%h valid=%b", c, a_lanes, a_valid);
         if (c < 3) step();
      end
      #3 rst_n = 1'b0;
      #1;
      chk("midreset a_flags", 128'({a_valid, a_busy, a_done, a_ready}), 128'(4'b0000));
      chk("midreset a_lanes", 128'(a_lanes), 128'(0));
      chk("midreset b_flags", 128'({b_valid, b_busy, b_done, b_ready}), 128'(4'b0000));
      chk("midreset b_lanes", 128'(b_lanes), 128'(0));
      step();
      chk("in_reset a_flags", 128'({a_valid, a_busy, a_done, a_ready}), 128'(4'b0000));
      #4 rst_n = 1'b1;
      start = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("after_reset start a %0d", c), 128'({a_valid, a_busy, a_done, a_ready}), 128'(4'b0001));
         chk($sformatf("after_reset start b %0d", c), 128'({b_valid, b_busy, b_done, b_ready}), 128'(4'b0001));
      end
      start = 1'b0;

      // Fresh load after reset, single-cycle START pulse.
      for (int r = 0; r < N; r++) load(a_row(r), r % 2, $sformatf("reload%0d", r));
      run_stream(1'b0, "run2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
